// File: rtl/cistercian_pkg.sv
// Shared Cistercian segment constants, used by both the decoder and this encoder.
package cistercian_pkg;

    localparam int unsigned SEG_W   = 5;
    localparam int unsigned DIGIT_W = 4;

    // Lit-segment codewords, bit4=U .. bit0=Y
    localparam logic [SEG_W-1:0] CIST_SEG_0  = 5'b00000;
    localparam logic [SEG_W-1:0] CIST_SEG_1  = 5'b10000;
    localparam logic [SEG_W-1:0] CIST_SEG_2  = 5'b01000;
    localparam logic [SEG_W-1:0] CIST_SEG_3  = 5'b00100;
    localparam logic [SEG_W-1:0] CIST_SEG_4  = 5'b00010;
    localparam logic [SEG_W-1:0] CIST_SEG_5  = 5'b10010;
    localparam logic [SEG_W-1:0] CIST_SEG_6  = 5'b00001;
    localparam logic [SEG_W-1:0] CIST_SEG_7  = 5'b10001;
    localparam logic [SEG_W-1:0] CIST_SEG_8  = 5'b01001;
    localparam logic [SEG_W-1:0] CIST_SEG_9  = 5'b11001;
    localparam logic [SEG_W-1:0] CIST_SEG_10 = 5'b11110;
    localparam logic [SEG_W-1:0] CIST_SEG_11 = 5'b10011;
    localparam logic [SEG_W-1:0] CIST_SEG_12 = 5'b11101;
    localparam logic [SEG_W-1:0] CIST_SEG_13 = 5'b11011;
    localparam logic [SEG_W-1:0] CIST_SEG_14 = 5'b10111;
    localparam logic [SEG_W-1:0] CIST_SEG_15 = 5'b01111;

    localparam logic [SEG_W-1:0] CIST_LAMP_TEST = 5'b11111;

    // Bit position of each segment within a channel vector
    typedef enum logic [2:0] {
        SegY = 3'd0,
        SegX = 3'd1,
        SegW = 3'd2,
        SegV = 3'd3,
        SegU = 3'd4
    } seg_idx_e;

endpackage

// File: rtl/cistercian_seg_to_digit.sv
// Combinational lookup from one lit-segment pattern to digit value and flags.
module cistercian_seg_to_digit
    import cistercian_pkg::*;
(
    input  logic [SEG_W-1:0]   seg_i,
    output logic [DIGIT_W-1:0] val_o,
    output logic               lt_o,
    output logic               err_o
);

    // Codeword table; anything else that is not all-lit is an error with value 0
    always_comb begin
        val_o = '0;
        lt_o  = 1'b0;
        err_o = 1'b0;
        case (seg_i)
            CIST_SEG_0:     val_o = 4'd0;
            CIST_SEG_1:     val_o = 4'd1;
            CIST_SEG_2:     val_o = 4'd2;
            CIST_SEG_3:     val_o = 4'd3;
            CIST_SEG_4:     val_o = 4'd4;
            CIST_SEG_5:     val_o = 4'd5;
            CIST_SEG_6:     val_o = 4'd6;
            CIST_SEG_7:     val_o = 4'd7;
            CIST_SEG_8:     val_o = 4'd8;
            CIST_SEG_9:     val_o = 4'd9;
            CIST_SEG_10:    val_o = 4'd10;
            CIST_SEG_11:    val_o = 4'd11;
            CIST_SEG_12:    val_o = 4'd12;
            CIST_SEG_13:    val_o = 4'd13;
            CIST_SEG_14:    val_o = 4'd14;
            CIST_SEG_15:    val_o = 4'd15;
            CIST_LAMP_TEST: lt_o  = 1'b1;
            default:        err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cistercian_segment_encoder.sv
// Reads back two Cistercian segment patterns, debounces the pair and reports each
// new stable pair once on a valid/ready output.
module cistercian_segment_encoder
    import cistercian_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEG_W-1:0]   seg1,
    input  logic [SEG_W-1:0]   seg2,
    input  logic               al,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] val1,
    output logic [DIGIT_W-1:0] val2,
    output logic               lt1,
    output logic               lt2,
    output logic               err1,
    output logic               err2
);

    localparam int unsigned PairW = 2 * SEG_W;
    localparam int unsigned CntW  = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][PairW-1:0] sync_q, sync_d;
    logic [PairW-1:0]   pat;
    logic [PairW-1:0]   cand_q, cand_d;
    logic [PairW-1:0]   last_q, last_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               reported_q, reported_d;
    logic               out_valid_q, out_valid_d;
    logic [DIGIT_W-1:0] val1_q, val1_d, val2_q, val2_d;
    logic               lt1_q, lt1_d, lt2_q, lt2_d;
    logic               err1_q, err1_d, err2_q, err2_d;
    logic               stable, report;
    logic [DIGIT_W-1:0] dec_val1, dec_val2;
    logic               dec_lt1, dec_lt2, dec_err1, dec_err2;

    // Decode the candidate, not the live pattern, so reported data matches last_q
    cistercian_seg_to_digit u_dec1 (
        .seg_i (cand_q[PairW-1:SEG_W]),
        .val_o (dec_val1),
        .lt_o  (dec_lt1),
        .err_o (dec_err1)
    );

    cistercian_seg_to_digit u_dec2 (
        .seg_i (cand_q[SEG_W-1:0]),
        .val_o (dec_val2),
        .lt_o  (dec_lt2),
        .err_o (dec_err2)
    );

    // Shift raw lines through the synchroniser; lit segments become 1 after the XOR
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {seg1, seg2}};
        pat    = sync_q[SYNC_STAGES-1] ^ {PairW{~al}};
    end

    // Settling counter, report decision and output handshake
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        reported_d  = reported_q;
        out_valid_d = out_valid_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        lt1_d       = lt1_q;
        lt2_d       = lt2_q;
        err1_d      = err1_q;
        err2_d      = err2_q;

        if (pat != cand_q) begin
            cand_d = pat;
            cnt_d  = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end

        stable = (pat == cand_q) && (cnt_q == CntMax);
        report = stable && (!reported_q || (cand_q != last_q)) && (!out_valid_q || out_ready);

        if (report) begin
            out_valid_d = 1'b1;
            last_d      = cand_q;
            reported_d  = 1'b1;
            val1_d      = dec_val1;
            val2_d      = dec_val2;
            lt1_d       = dec_lt1;
            lt2_d       = dec_lt2;
            err1_d      = dec_err1;
            err2_d      = dec_err2;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            reported_q  <= 1'b0;
            out_valid_q <= 1'b0;
            val1_q      <= '0;
            val2_q      <= '0;
            lt1_q       <= 1'b0;
            lt2_q       <= 1'b0;
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            reported_q  <= reported_d;
            out_valid_q <= out_valid_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            lt1_q       <= lt1_d;
            lt2_q       <= lt2_d;
            err1_q      <= err1_d;
            err2_q      <= err2_d;
        end
    end

    assign out_valid = out_valid_q;
    assign val1      = val1_q;
    assign val2      = val2_q;
    assign lt1       = lt1_q;
    assign lt2       = lt2_q;
    assign err1      = err1_q;
    assign err2      = err2_q;

endmodule

// File: tb/tb_cistercian_segment_encoder.sv
// Directed bench for cistercian_segment_encoder with default parameters.
module tb_cistercian_segment_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] seg1, seg2;
    logic       al, out_ready;
    logic       out_valid;
    logic [3:0] val1, val2;
    logic       lt1, lt2, err1, err2;

    int checks   = 0;
    int failures = 0;
    int pulses;
    logic [3:0] first_v1, last_v1;

    typedef struct {
        logic [4:0] s1;
        logic [4:0] s2;
        logic       al;
        logic [3:0] v1;
        logic [3:0] v2;
        logic       lt1;
        logic       lt2;
        logic       e1;
        logic       e2;
    } vec_t;

    vec_t vecs[$];

    cistercian_segment_encoder #(
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg1      (seg1),
        .seg2      (seg2),
        .al        (al),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .val1      (val1),
        .val2      (val2),
        .lt1       (lt1),
        .lt2       (lt2),
        .err1      (err1),
        .err2      (err2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Edge 0 is the first posedge after the call; returns -1 if no report within budget
    task automatic wait_valid(input int max_edges, output int edges);
        edges = -1;
        for (int k = 0; k < max_edges; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic watch(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                last_v1 = val1;
                if (pulses == 1) first_v1 = val1;
            end
        end
    endtask

    function automatic void add(input logic [4:0] s1, input logic [4:0] s2, input logic a,
                                input logic [3:0] v1, input logic [3:0] v2,
                                input logic l1, input logic l2, input logic e1,
                                input logic e2);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.al = a; v.v1 = v1; v.v2 = v2;
        v.lt1 = l1; v.lt2 = l2; v.e1 = e1; v.e2 = e2;
        vecs.push_back(v);
    endfunction

    initial begin
        int e;

        add(5'b00000, 5'b01111, 1'b1,  0, 15, 0, 0, 0, 0);
        add(5'b10000, 5'b10111, 1'b1,  1, 14, 0, 0, 0, 0);
        add(5'b01000, 5'b11011, 1'b1,  2, 13, 0, 0, 0, 0);
        add(5'b00100, 5'b11101, 1'b1,  3, 12, 0, 0, 0, 0);
        add(5'b00010, 5'b10011, 1'b1,  4, 11, 0, 0, 0, 0);
        add(5'b10010, 5'b11110, 1'b1,  5, 10, 0, 0, 0, 0);
        add(5'b00001, 5'b11001, 1'b1,  6,  9, 0, 0, 0, 0);
        add(5'b10001, 5'b01001, 1'b1,  7,  8, 0, 0, 0, 0);
        add(5'b01001, 5'b10001, 1'b1,  8,  7, 0, 0, 0, 0);
        add(5'b11001, 5'b00001, 1'b1,  9,  6, 0, 0, 0, 0);
        add(5'b11110, 5'b10010, 1'b1, 10,  5, 0, 0, 0, 0);
        add(5'b10011, 5'b00010, 1'b1, 11,  4, 0, 0, 0, 0);
        add(5'b11101, 5'b00100, 1'b1, 12,  3, 0, 0, 0, 0);
        add(5'b11011, 5'b01000, 1'b1, 13,  2, 0, 0, 0, 0);
        add(5'b10111, 5'b10000, 1'b1, 14,  1, 0, 0, 0, 0);
        add(5'b01111, 5'b00000, 1'b1, 15,  0, 0, 0, 0, 0);
        add(5'b11111, 5'b10100, 1'b1,  0,  0, 1, 0, 0, 1);
        add(5'b01100, 5'b11111, 1'b1,  0,  0, 0, 1, 1, 0);
        // Lit-low: raw 10000 is lit 01111, raw 00000 is all lit
        add(5'b10000, 5'b00000, 1'b0, 15,  0, 0, 1, 0, 0);
        // Raw 01011 is lit 10100, not a codeword
        add(5'b01011, 5'b00000, 1'b0,  0,  0, 0, 1, 1, 0);
        add(5'b00000, 5'b00000, 1'b1,  0,  0, 0, 0, 0, 0);

        // Reset state and first report after release
        rst_n = 1'b0; seg1 = '0; seg2 = '0; al = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_vals", int'({val1, val2, lt1, lt2, err1, err2}), 0);
        rst_n = 1'b1;
        wait_valid(20, e);
        check("release_report_edge", e, 4);
        check("release_val1", int'(val1), 0);
        check("release_val2", int'(val2), 0);
        check("release_flags", int'({lt1, lt2, err1, err2}), 0);
        pulses = 0;
        watch(20);
        check("idle_no_report", pulses, 0);

        // Latency of a clean change
        seg1 = 5'b11110; seg2 = 5'b01001;
        wait_valid(20, e);
        check("latency_edge", e, 7);
        check("latency_val1", int'(val1), 10);
        check("latency_val2", int'(val2), 8);
        check("latency_flags", int'({lt1, lt2, err1, err2}), 0);
        @(negedge clk);
        check("latency_pulse_drop", int'(out_valid), 0);

        // Decode table
        foreach (vecs[i]) begin
            seg1 = vecs[i].s1; seg2 = vecs[i].s2; al = vecs[i].al;
            wait_valid(20, e);
            check($sformatf("vec%0d_seen", i), int'(e >= 0), 1);
            check($sformatf("vec%0d_val1", i), int'(val1), int'(vecs[i].v1));
            check($sformatf("vec%0d_val2", i), int'(val2), int'(vecs[i].v2));
            check($sformatf("vec%0d_lt", i), int'({lt1, lt2}), int'({vecs[i].lt1, vecs[i].lt2}));
            check($sformatf("vec%0d_err", i), int'({err1, err2}), int'({vecs[i].e1, vecs[i].e2}));
        end

        // Short glitch returning to last reported pair: no report
        repeat (10) @(negedge clk);
        pulses = 0;
        seg1 = 5'b10000;
        watch(3);
        seg1 = 5'b00000;
        watch(20);
        check("glitch3_no_report", pulses, 0);

        // Held pulse reports, and returning to the old pair reports it again
        pulses = 0;
        seg1 = 5'b10000;
        watch(6);
        seg1 = 5'b00000;
        watch(25);
        check("pulse6_reports", pulses, 2);
        check("pulse6_first_val1", int'(first_v1), 1);
        check("pulse6_last_val1", int'(last_v1), 0);

        // Backpressure: hold, then back-to-back load on the handshake edge
        out_ready = 1'b0;
        seg1 = 5'b10010;
        wait_valid(20, e);
        check("bp_first_seen", int'(e >= 0), 1);
        check("bp_first_val1", int'(val1), 5);
        seg1 = 5'b00001;
        repeat (12) @(negedge clk);
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_val1", int'(val1), 5);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b2b_valid", int'(out_valid), 1);
        check("bp_b2b_val1", int'(val1), 6);
        @(negedge clk);
        check("bp_drop_valid", int'(out_valid), 0);

        // Asynchronous reset while holding a result, then re-report
        out_ready = 1'b0;
        seg1 = 5'b00100;
        wait_valid(20, e);
        check("rst_pre_valid", int'(out_valid), 1);
        check("rst_pre_val1", int'(val1), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", int'(out_valid), 0);
        check("rst_async_val1", int'(val1), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        wait_valid(20, e);
        check("rst_rereport_edge", e, 7);
        check("rst_rereport_val1", int'(val1), 3);
        check("rst_rereport_val2", int'(val2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
